// File: rtl/smem_task_mailbox.sv
// PL-side shared-memory task mailbox: host-visible input/output buffers, control/status
// registers and the PL_READY -> TV_IN_READY -> engine -> TV_OUT_READY handshake.
module smem_task_mailbox #(
  parameter int unsigned DEPTH_WORDS    = 512,
  parameter logic [31:0] ENABLED_MASK   = 32'h0000_FFFE,
  parameter int unsigned INIT_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [16:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_ack,
  output logic [31:0] host_rdata,
  output logic        eng_start,
  output logic [4:0]  eng_task,
  input  logic        eng_done,
  input  logic [8:0]  eng_in_addr,
  output logic [31:0] eng_in_data,
  input  logic        eng_out_we,
  input  logic [8:0]  eng_out_addr,
  input  logic [31:0] eng_out_data
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam int unsigned TASK_W = 5;
  localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [2:0] R_PL_READY = 3'd0;
  localparam logic [2:0] R_ENABLED  = 3'd1;
  localparam logic [2:0] R_TASK     = 3'd2;
  localparam logic [2:0] R_TV_IN    = 3'd3;
  localparam logic [2:0] R_TV_OUT   = 3'd4;
  localparam logic [2:0] R_STATUS   = 3'd5;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_CHECK,
    ST_BUSY,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [TASK_W-1:0]   cur_task_q, cur_task_d;
  logic [TASK_W-1:0]   eng_task_q, eng_task_d;
  logic                eng_start_q, eng_start_d;
  logic                tv_in_q, tv_in_d;
  logic                tv_out_q, tv_out_d;
  logic [2:0]          status_q, status_d;
  logic                host_ack_q;
  logic [31:0]         host_rdata_q;
  logic [31:0]         eng_in_data_q;

  logic [31:0] in_mem  [DEPTH_WORDS];
  logic [31:0] out_mem [DEPTH_WORDS];

  // Host address decode
  logic          acc_in, acc_out, acc_reg;
  logic [2:0]    reg_sel;
  logic [AW-1:0] word_idx;
  logic          host_wr, busy_lock, in_wr_ok, blocked_wr;
  logic [31:0]   reg_rdata;
  logic          unused_addr_bits;

  assign reg_sel          = host_addr[4:2];
  assign word_idx         = host_addr[AW+1:2];
  assign acc_in           = (host_addr[16:12] == 5'd0) && !host_addr[11];
  assign acc_out          = (host_addr[16:12] == 5'd0) &&  host_addr[11];
  assign acc_reg          = host_addr[16] && (host_addr[15:5] == 11'd0) && (reg_sel <= R_STATUS);
  assign unused_addr_bits = ^host_addr[1:0];

  assign host_wr    = host_req && host_we;
  assign busy_lock  = (state_q == ST_CHECK) || (state_q == ST_BUSY);
  assign in_wr_ok   = host_wr && acc_in && !busy_lock;
  assign blocked_wr = host_wr && busy_lock &&
                      (acc_in || (acc_reg && ((reg_sel == R_TASK) || (reg_sel == R_TV_IN))));

  // Register read mux, sampled into host_rdata on the request cycle
  always_comb begin
    reg_rdata = '0;
    if (acc_reg) begin
      case (reg_sel)
        R_PL_READY: reg_rdata = {31'd0, (state_q != ST_INIT)};
        R_ENABLED:  reg_rdata = ENABLED_MASK;
        R_TASK:     reg_rdata = {27'd0, cur_task_q};
        R_TV_IN:    reg_rdata = {31'd0, tv_in_q};
        R_TV_OUT:   reg_rdata = {31'd0, tv_out_q};
        R_STATUS:   reg_rdata = {29'd0, status_q};
        default:    reg_rdata = '0;
      endcase
    end
  end

  // Next-state logic: host register writes first, FSM events override
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    cur_task_d  = cur_task_q;
    eng_task_d  = eng_task_q;
    eng_start_d = 1'b0;
    tv_in_d     = tv_in_q;
    tv_out_d    = tv_out_q;
    status_d    = status_q;

    if (host_wr && acc_reg && !busy_lock) begin
      if (reg_sel == R_TASK) begin
        cur_task_d = host_wdata[TASK_W-1:0];
      end
      if (reg_sel == R_TV_IN) begin
        tv_in_d = host_wdata[0];
        if (host_wdata[0]) begin
          tv_out_d = 1'b0;
        end
      end
    end
    if (host_wr && acc_reg && (reg_sel == R_STATUS)) begin
      status_d = status_q & ~host_wdata[2:0];
    end
    // Hardware-set flags take priority over a same-cycle clear
    if (blocked_wr) begin
      status_d[2] = 1'b1;
    end

    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end
      ST_IDLE: begin
        if (tv_in_q) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (ENABLED_MASK[cur_task_q]) begin
          eng_start_d = 1'b1;
          eng_task_d  = cur_task_q;
          tmo_cnt_d   = '0;
          state_d     = ST_BUSY;
        end else begin
          status_d[0] = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_BUSY: begin
        // A done on the final count wins over the timeout
        if (eng_done) begin
          state_d = ST_DONE;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          status_d[1] = 1'b1;
          state_d     = ST_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      tv_out_d = 1'b1;
      tv_in_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      cur_task_q  <= '0;
      eng_task_q  <= '0;
      eng_start_q <= 1'b0;
      tv_in_q     <= 1'b0;
      tv_out_q    <= 1'b0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      cur_task_q  <= cur_task_d;
      eng_task_q  <= eng_task_d;
      eng_start_q <= eng_start_d;
      tv_in_q     <= tv_in_d;
      tv_out_q    <= tv_out_d;
      status_q    <= status_d;
    end
  end

  // Host response: ack one cycle after every request, buffer data read synchronously
  always_ff @(posedge clk) begin
    if (rst) begin
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      host_ack_q <= host_req;
      if (host_req) begin
        if (host_we) begin
          host_rdata_q <= '0;
        end else if (acc_in) begin
          host_rdata_q <= in_mem[word_idx];
        end else if (acc_out) begin
          host_rdata_q <= out_mem[word_idx];
        end else begin
          host_rdata_q <= reg_rdata;
        end
      end
    end
  end

  // Input buffer: host write port, engine read port
  always_ff @(posedge clk) begin
    if (in_wr_ok) begin
      in_mem[word_idx] <= host_wdata;
    end
    eng_in_data_q <= in_mem[eng_in_addr];
  end

  // Output buffer: engine is the only writer; host reads see pre-write data
  always_ff @(posedge clk) begin
    if (eng_out_we) begin
      out_mem[eng_out_addr] <= eng_out_data;
    end
  end

  assign host_ack    = host_ack_q;
  assign host_rdata  = host_rdata_q;
  assign eng_start   = eng_start_q;
  assign eng_task    = eng_task_q;
  assign eng_in_data = eng_in_data_q;

endmodule

// File: tb/tb_smem_task_mailbox.sv
// Directed bench for smem_task_mailbox: init timing, task run, disabled task,
// timeout, busy-write protection, back-to-back reads and reset mid-task.
module tb_smem_task_mailbox;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_req, host_we;
  logic [16:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic        eng_start;
  logic [4:0]  eng_task;
  logic        eng_done;
  logic [8:0]  eng_in_addr;
  logic [31:0] eng_in_data;
  logic        eng_out_we;
  logic [8:0]  eng_out_addr;
  logic [31:0] eng_out_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (eng_start === 1'b1) start_cnt <= start_cnt + 1;

  smem_task_mailbox #(
    .DEPTH_WORDS   (512),
    .ENABLED_MASK  (32'h0000_FFFE),
    .INIT_CYCLES   (16),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .eng_start   (eng_start),
    .eng_task    (eng_task),
    .eng_done    (eng_done),
    .eng_in_addr (eng_in_addr),
    .eng_in_data (eng_in_data),
    .eng_out_we  (eng_out_we),
    .eng_out_addr(eng_out_addr),
    .eng_out_data(eng_out_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic host_wr(input logic [16:0] a, input logic [31:0] d);
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_req = 1'b0; host_we = 1'b0;
    check("wr_ack", 32'(host_ack), 32'd1);
  endtask

  task automatic host_rd(input logic [16:0] a, output logic [31:0] d);
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = a;
    @(negedge clk);
    host_req = 1'b0;
    check("rd_ack", 32'(host_ack), 32'd1);
    d = host_rdata;
  endtask

  task automatic wait_start(input logic [4:0] task_exp, output int c);
    bit seen;
    seen = 1'b0;
    c = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (eng_start === 1'b1) begin
        seen = 1'b1;
        c = cyc;
      end
    end
    check("eng_start_seen", 32'(seen), 32'd1);
    check("eng_task", 32'(eng_task), 32'(task_exp));
  endtask

  initial begin
    logic [31:0] rd;
    int zeros, ack_miss, c_start, c_det;
    bit got_one, first;

    rst = 1'b1; host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    eng_done = 1'b0; eng_in_addr = '0; eng_out_we = 1'b0; eng_out_addr = '0; eng_out_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(host_ack), 32'd0);
    check("rst_rdata", host_rdata, 32'd0);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_eng_task", 32'(eng_task), 32'd0);

    // Poll PL_READY every cycle from reset release
    rst = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 17'h10000;
    zeros = 0; ack_miss = 0; got_one = 1'b0;
    for (int i = 0; i < 40 && !got_one; i++) begin
      @(negedge clk);
      if (host_ack !== 1'b1) ack_miss++;
      if (host_rdata === 32'd1) got_one = 1'b1;
      else zeros++;
    end
    host_req = 1'b0;
    check("init_zero_reads", 32'(zeros), 32'd16);
    check("pl_ready_set", 32'(got_one), 32'd1);
    check("init_ack_miss", 32'(ack_miss), 32'd0);
    host_rd(17'h10004, rd); check("enabled_tasks", rd, 32'h0000_FFFE);

    // Task 1: fill input buffer, run, protect against busy writes
    for (int i = 0; i < 250; i++) host_wr(17'(i * 4), 32'h0000_1000 + 32'(i));
    host_rd(17'h0000C, rd); check("in3_readback", rd, 32'h0000_1003);
    host_rd(17'h003E4, rd); check("in249_readback", rd, 32'h0000_10F9);
    host_wr(17'h10008, 32'd1);
    host_rd(17'h10008, rd); check("cur_task_rb", rd, 32'd1);
    host_wr(17'h1000C, 32'd1);
    wait_start(5'd1, c_start);
    host_wr(17'h0000C, 32'hA5A5_A5A5);
    host_wr(17'h10008, 32'd7);
    host_rd(17'h0000C, rd); check("busy_in3_kept", rd, 32'h0000_1003);
    host_rd(17'h10014, rd); check("busy_write_status", rd, 32'h0000_0004);
    host_rd(17'h10008, rd); check("busy_task_kept", rd, 32'd1);
    @(negedge clk); eng_in_addr = 9'd3;
    @(negedge clk); check("eng_in3", eng_in_data, 32'h0000_1003);
    eng_out_we = 1'b1; eng_out_addr = 9'd0; eng_out_data = 32'h0000_0001;
    @(negedge clk); eng_out_we = 1'b0;
    repeat (5) @(negedge clk);
    check("one_start_pulse", 32'(start_cnt), 32'd1);
    eng_done = 1'b1;
    @(negedge clk); eng_done = 1'b0;
    repeat (3) @(negedge clk);
    host_rd(17'h10010, rd); check("t1_tv_out", rd, 32'd1);
    host_rd(17'h1000C, rd); check("t1_tv_in", rd, 32'd0);
    host_rd(17'h00800, rd); check("t1_out0", rd, 32'h0000_0001);
    host_rd(17'h10014, rd); check("t1_status", rd, 32'h0000_0004);
    host_wr(17'h10014, 32'h0000_0004);
    host_rd(17'h10014, rd); check("t1_status_clr", rd, 32'd0);

    // Task 20 is not enabled
    host_wr(17'h10008, 32'd20);
    host_wr(17'h1000C, 32'd1);
    repeat (5) @(negedge clk);
    host_rd(17'h10010, rd); check("t20_tv_out", rd, 32'd1);
    host_rd(17'h1000C, rd); check("t20_tv_in", rd, 32'd0);
    host_rd(17'h10014, rd); check("t20_status", rd, 32'h0000_0001);
    check("t20_no_start", 32'(start_cnt), 32'd1);
    host_wr(17'h10014, 32'h0000_0001);
    host_rd(17'h10014, rd); check("t20_status_clr", rd, 32'd0);

    // Timeout: task 2 with no eng_done
    host_wr(17'h10008, 32'd2);
    host_wr(17'h1000C, 32'd1);
    wait_start(5'd2, c_start);
    host_req = 1'b1; host_we = 1'b0; host_addr = 17'h10010;
    got_one = 1'b0; first = 1'b1; c_det = 0;
    for (int i = 0; i < 100 && !got_one; i++) begin
      @(negedge clk);
      if (first) check("tmo_tv_out_cleared", host_rdata, 32'd0);
      first = 1'b0;
      if (host_rdata === 32'd1) begin
        got_one = 1'b1;
        c_det = cyc;
      end
    end
    host_req = 1'b0;
    check("tmo_tv_out_seen", 32'(got_one), 32'd1);
    // Read data reflects the register before the sampling edge, hence 64 + 1
    check("tmo_latency", 32'(c_det - c_start), 32'd65);
    host_rd(17'h10014, rd); check("tmo_status", rd, 32'h0000_0002);
    check("tmo_start_cnt", 32'(start_cnt), 32'd2);
    host_wr(17'h10014, 32'h0000_0002);

    // Output buffer is read-only; unmapped offsets read 0
    host_wr(17'h00800, 32'h0000_0055);
    host_rd(17'h00800, rd); check("out_ro", rd, 32'h0000_0001);
    host_wr(17'h10018, 32'hFFFF_FFFF);
    host_rd(17'h10018, rd); check("unmapped", rd, 32'd0);

    // Host read vs engine write to the same word in one cycle
    @(negedge clk); eng_out_we = 1'b1; eng_out_addr = 9'd1; eng_out_data = 32'hDEAD_BEEF;
    @(negedge clk); eng_out_we = 1'b0;
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = 17'h00804;
    eng_out_we = 1'b1; eng_out_addr = 9'd1; eng_out_data = 32'h1234_5678;
    @(negedge clk); host_req = 1'b0; eng_out_we = 1'b0;
    check("rd_old_data", host_rdata, 32'hDEAD_BEEF);

    // Back-to-back reads
    @(negedge clk); host_req = 1'b1; host_we = 1'b0; host_addr = 17'h00800;
    @(negedge clk); check("b2b_ack0", 32'(host_ack), 32'd1); check("b2b_d0", host_rdata, 32'h0000_0001);
    host_addr = 17'h00804;
    @(negedge clk); check("b2b_ack1", 32'(host_ack), 32'd1); check("b2b_d1", host_rdata, 32'h1234_5678);
    host_addr = 17'h10010;
    @(negedge clk); check("b2b_ack2", 32'(host_ack), 32'd1); check("b2b_d2", host_rdata, 32'd1);
    host_req = 1'b0;
    @(negedge clk); check("b2b_ack_end", 32'(host_ack), 32'd0);

    // Reset while BUSY
    host_wr(17'h10008, 32'd3);
    host_wr(17'h1000C, 32'd1);
    wait_start(5'd3, c_start);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_start", 32'(eng_start), 32'd0);
    check("mid_rst_ack", 32'(host_ack), 32'd0);
    rst = 1'b0;
    host_rd(17'h10000, rd); check("mid_rst_pl_ready", rd, 32'd0);
    host_rd(17'h10010, rd); check("mid_rst_tv_out", rd, 32'd0);
    host_rd(17'h10014, rd); check("mid_rst_status", rd, 32'd0);
    host_rd(17'h10008, rd); check("mid_rst_task", rd, 32'd0);
    check("mid_rst_start_cnt", 32'(start_cnt), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/smem_task_mailbox.md
Name: smem_task_mailbox

Overview:
- PL-side responder for the PS shared-memory task protocol at SMEM_BASEADDR (0xA000_0000).
- Holds the 512-word input buffer, the 512-word output buffer and the control/status registers.
- Sequences the handshake PL_READY -> TV_IN_READY -> engine start/done -> TV_OUT_READY.
- Sits between the AXI-to-native bridge (host side) and the task engine.

Parameters:
- DEPTH_WORDS, 512: words in each of the input and output buffers.
- ENABLED_MASK, 32'h0000_FFFE: bit n set means task n is implemented; read back via ENABLED_TASKS.
- INIT_CYCLES, 16: cycles after reset before PL_READY asserts.
- TIMEOUT_CYCLES, 1048576: maximum cycles in BUSY before forced completion.

Ports:
- clk  in  1  system clock; everything is in this domain.
- rst  in  1  synchronous, active-high reset.
- host_req  in  1  access request from the bridge, single-cycle pulse.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  17  byte offset from SMEM_BASEADDR; bits [1:0] are ignored.
- host_wdata  in  32  write data.
- host_ack  out  1  completes the access; asserts exactly 1 cycle after host_req.
- host_rdata  out  32  read data, valid while host_ack=1.
- eng_start  out  1  one-cycle start pulse to the task engine.
- eng_task  out  5  current task number, stable from eng_start until done.
- eng_done  in  1  engine completion pulse.
- eng_in_addr  in  9  input buffer read address.
- eng_in_data  out  32  input buffer read data, 1-cycle latency.
- eng_out_we  in  1  output buffer write enable.
- eng_out_addr  in  9  output buffer write address.
- eng_out_data  in  32  output buffer write data.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=INIT; eng_start=0; host_ack=0; host_rdata=0; CURRENT_TASK=0; TV_IN_READY=0; TV_OUT_READY=0; STATUS=0; timeout counter=0. Buffer contents are not reset.
- Address map (byte offsets):
  - 0x00000-0x007FF: input buffer, host RW.
  - 0x00800-0x00FFF: output buffer, host RO; writes are ignored but still acked.
  - 0x10000 PL_READY: RO, 1 when state != INIT.
  - 0x10004 ENABLED_TASKS: RO, returns ENABLED_MASK.
  - 0x10008 CURRENT_TASK: RW, bits [4:0], reads back zero-extended.
  - 0x1000C TV_IN_READY: RW bit 0.
  - 0x10010 TV_OUT_READY: RO bit 0.
  - 0x10014 STATUS: bit0 task_not_enabled, bit1 timeout, bit2 write_while_busy. Sticky; write 1 to clear.
  - Any other offset reads 0, ignores writes, and is still acked.
- Host access:
  - Every host_req gives host_ack on the next cycle.
  - Buffer reads are registered RAM reads, so data arrives together with host_ack.
  - Back-to-back requests on consecutive cycles are legal.
- FSM:
  - INIT: count INIT_CYCLES, then go to IDLE.
  - IDLE: when TV_IN_READY=1, go to CHECK.
  - CHECK:
    - If ENABLED_MASK[CURRENT_TASK]=1: assert eng_start for this one cycle, latch eng_task, clear the timeout counter, go to BUSY.
    - Otherwise: set STATUS bit0 and go to DONE.
  - BUSY:
    - On eng_done: go to DONE.
    - When the counter reaches TIMEOUT_CYCLES-1: set STATUS bit1 and go to DONE.
  - DONE (one cycle): set TV_OUT_READY=1, clear TV_IN_READY=0, go to IDLE.
- Starting a new task: a host write of 1 to TV_IN_READY clears TV_OUT_READY in the same cycle. Writing 0 only clears the bit.
- Writes in CHECK or BUSY:
  - Writes to the input buffer, CURRENT_TASK or TV_IN_READY are dropped and set STATUS bit2.
  - eng_task and the input buffer therefore stay stable while the engine runs.
- Engine ports: the engine may write the output buffer in any state; the host only sees stable output after TV_OUT_READY=1.
- Simultaneous events:
  - eng_done in the same cycle as the last timeout count: done wins, timeout is not flagged.
  - eng_done outside BUSY is ignored.
  - Host buffer write and engine write to the same output address in one cycle: engine wins.
  - Host read and engine write to the same address in one cycle: host gets the old data.
- Reset mid-task: returns to INIT and clears all flags; eng_start stays low.

Test Plan:
- Reset release, poll 0x10000 every cycle -> reads 0 for 16 cycles after rst deasserts, then 1. Read 0x10004 -> 0x0000FFFE.
- Write input[0..249], CURRENT_TASK=1, TV_IN_READY=1 -> eng_start one pulse with eng_task=1. Engine writes out[0]=0x1, done after 300 cycles -> TV_OUT_READY=1, TV_IN_READY=0, read 0x800 -> 0x00000001.
- CURRENT_TASK=20, TV_IN_READY=1 -> no eng_start, TV_OUT_READY=1, STATUS=0x1. Write 0x1 to STATUS -> reads 0.
- Engine never signals done (TIMEOUT_CYCLES=64 in bench) -> TV_OUT_READY=1 exactly 64 cycles after eng_start, STATUS=0x2.
- Write 0xA5A5A5A5 to input[3] during BUSY -> input[3] unchanged, STATUS bit2 set. Engine read of address 3 returns the pre-task value.
- Back-to-back host reads of 0x800, 0x804, 0x10010 -> three host_ack pulses on consecutive cycles with correct data. Assert rst in BUSY -> PL_READY=0, TV_OUT_READY=0.
